// File: rtl/imm4_alloc.sv
// Writer-side allocator for the 4-wide immediate register file: picks the lowest
// free row per accepted bundle, drives the row write port and tracks occupancy.
module imm4_alloc #(
   parameter  int SIZE  = 32,
   parameter  int WIDTH = 32,
   localparam int ROWS  = SIZE / 4,
   localparam int TW    = $clog2(ROWS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_imm0,
   input  logic [WIDTH-1:0] i_imm1,
   input  logic [WIDTH-1:0] i_imm2,
   input  logic [WIDTH-1:0] i_imm3,
   output logic             o_tag_valid,
   output logic [TW-1:0]    o_tag,
   output logic             o_we,
   output logic [ROWS-1:0]  o_waddr,
   output logic [WIDTH-1:0] o_wdata0,
   output logic [WIDTH-1:0] o_wdata1,
   output logic [WIDTH-1:0] o_wdata2,
   output logic [WIDTH-1:0] o_wdata3,
   input  logic             i_rel,
   input  logic [ROWS-1:0]  i_rel_rows,
   input  logic             i_flush,
   output logic [TW:0]      o_free_cnt
);

   logic [ROWS-1:0] free_r;
   logic [ROWS-1:0] free_nxt_s;
   logic [ROWS-1:0] sel_oh_s;
   logic [TW-1:0]   sel_idx_s;
   logic            accept_s;

   function automatic logic [TW:0] popcount(input logic [ROWS-1:0] v);
      logic [TW:0] c;
      c = {(TW+1){1'b0}};
      for (int i = 0; i < ROWS; i++) begin
         c = c + {{TW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Gate ready with reset so dispatch never sees a free row while held in reset.
   assign o_ready  = i_rst_n & (|free_r) & ~i_flush;
   assign accept_s = i_valid & o_ready;

   // Lowest-index free row, scanned from the top so the lowest hit wins.
   always_comb begin
      sel_oh_s  = {ROWS{1'b0}};
      sel_idx_s = {TW{1'b0}};
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (free_r[i]) begin
            sel_oh_s    = {ROWS{1'b0}};
            sel_oh_s[i] = 1'b1;
            sel_idx_s   = TW'(i);
         end else begin
            sel_oh_s  = sel_oh_s;
            sel_idx_s = sel_idx_s;
         end
      end
   end

   // Next occupancy: flush frees everything; otherwise a release of the row being
   // allocated in the same cycle wins and leaves it free.
   always_comb begin
      free_nxt_s = free_r;
      if (i_flush) begin
         free_nxt_s = {ROWS{1'b1}};
      end else begin
         if (accept_s) begin
            free_nxt_s = free_nxt_s & ~sel_oh_s;
         end else begin
            free_nxt_s = free_nxt_s;
         end
         if (i_rel) begin
            free_nxt_s = free_nxt_s | i_rel_rows;
         end else begin
            free_nxt_s = free_nxt_s;
         end
      end
   end

   // State and write-port registers; address/tag/data hold between accepts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         free_r      <= {ROWS{1'b1}};
         o_free_cnt  <= (TW+1)'(ROWS);
         o_we        <= 1'b0;
         o_tag_valid <= 1'b0;
         o_waddr     <= {ROWS{1'b0}};
         o_tag       <= {TW{1'b0}};
         o_wdata0    <= {WIDTH{1'b0}};
         o_wdata1    <= {WIDTH{1'b0}};
         o_wdata2    <= {WIDTH{1'b0}};
         o_wdata3    <= {WIDTH{1'b0}};
      end else begin
         free_r      <= free_nxt_s;
         o_free_cnt  <= popcount(free_nxt_s);
         o_we        <= accept_s;
         o_tag_valid <= accept_s;
         if (accept_s) begin
            o_waddr  <= sel_oh_s;
            o_tag    <= sel_idx_s;
            o_wdata0 <= i_imm0;
            o_wdata1 <= i_imm1;
            o_wdata2 <= i_imm2;
            o_wdata3 <= i_imm3;
         end
      end
   end

endmodule

// File: doc/imm4_alloc.md
Name: imm4_alloc

Overview:
- Writer-side front end for the 4-wide immediate register file (SIZE entries, SIZE/4 rows of 4 entries).
- Accepts one bundle of four decoded immediates per cycle from dispatch over a valid/ready handshake.
- Allocates a free row and drives the file's row-granular write port (write enable, one-hot row address, four data words).
- Returns the row tag to dispatch, and tracks row occupancy with commit-time release and mispredict flush.

Parameters:
- SIZE, 32, total immediate entries; must be a multiple of 4, SIZE/4 >= 2.
- WIDTH, 32, immediate width in bits.
- ROWS = SIZE/4 (localparam), number of rows.
- TW = $clog2(ROWS) (localparam), row tag width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  dispatch presents a bundle.
- o_ready  output  1  a row can be accepted this cycle.
- i_imm0..i_imm3  input  WIDTH each  immediates for slots 0..3.
- o_tag_valid  output  1  o_tag is valid (one-cycle pulse).
- o_tag  output  TW  allocated row index; slot k entry address = {o_tag, k[1:0]}.
- o_we  output  1  write enable to the file.
- o_waddr  output  ROWS  one-hot row select to the file.
- o_wdata0..o_wdata3  output  WIDTH each  write data to the file.
- i_rel  input  1  release request.
- i_rel_rows  input  ROWS  bitmask of rows to release (several allowed per cycle).
- i_flush  input  1  free all rows, cancel any accept this cycle.
- o_free_cnt  output  TW+1  number of free rows.

Behaviour:
- State: free bitmap free[ROWS-1:0], where 1 = free.
- Reset (async, i_rst_n=0):
  - free = all ones; o_free_cnt = ROWS.
  - o_we, o_tag_valid, o_waddr, o_tag, o_wdata* = 0.
  - o_ready = 0 while reset is asserted.
- o_ready = |free & ~i_flush (combinational from registered state).
- Accept = i_valid & o_ready at a rising edge.
- Selected row = lowest-index set bit of free, evaluated before this cycle's releases.
- Latency 1: on the edge of an accepted cycle, register:
  - o_we=1, o_tag_valid=1
  - o_waddr = one-hot(selected), o_tag = selected
  - o_wdata0..3 = i_imm0..3
  - clear free[selected]
- Cycles with no accept: o_we=0, o_tag_valid=0; o_waddr/o_tag/o_wdata hold their last values.
- Back-to-back accepts allowed every cycle while free rows remain; each accept selects a distinct row.
- Release: when i_rel=1, free |= i_rel_rows at the edge.
  - Releasing an already-free row has no effect.
  - A row released in cycle N is allocatable from cycle N+1 (no same-cycle bypass).
- Accept and release in the same cycle:
  - next free = (free & ~sel_onehot) | i_rel_rows.
  - A release bit for the row being allocated that same cycle wins (row ends free). Dispatch must never do this; verification flags it as a protocol error.
- Flush:
  - next free = all ones; o_we=0, o_tag_valid=0 on the next cycle.
  - An o_we already registered in the flush cycle still completes its write (harmless, row becomes free).
  - Flush dominates accept and release.
- Full: free=0 -> o_ready=0; i_valid is held by dispatch and bundle data must stay stable.
- o_free_cnt = popcount(free), registered alongside free.
- Reset asserted mid-operation: state returns to reset values immediately; a pending write is dropped.
- All widths unsigned; no arithmetic on data, only pass-through.

Test Plan:
- Post-reset, i_valid=1 for 3 cycles, imm0=0x11, imm1=0x22, imm2=0x33, imm3=0x44 (changing per cycle):
  - o_tag = 0, 1, 2 on consecutive cycles, o_waddr = 0x01, 0x02, 0x04.
  - o_free_cnt goes 8 -> 5.
  - Read-back through the file at address {tag,k} returns the matching data.
- Fill all 8 rows with i_valid held high:
  - o_ready drops the cycle after the 8th accept; o_free_cnt=0.
  - A 9th bundle stalls until i_rel=1, i_rel_rows=0x20; then o_tag=5 one cycle after the release edge.
- With rows 0..3 busy:
  - i_rel_rows=0x05 plus a simultaneous accept allocates row 4 (not 0) in that cycle.
  - The next accept gets row 0.
- Flush with 6 rows busy while i_valid=1:
  - No o_we the following cycle; o_free_cnt=8.
  - The next accept gets tag 0.
- Assert i_rst_n=0 asynchronously mid-stream (between edges):
  - o_we and o_tag_valid fall immediately; o_free_cnt=8.
  - After deassert, first tag=0.
- Release of an already-free row (i_rel_rows=0x80 with row 7 free): o_free_cnt unchanged; no spurious o_we.
